rf_writeback_queue: RTL and testbench

Buffers register-file writeback requests from the execute/memory stages and drains them, one per cycle, into the single write port of the 4 x 24-bit register file (`regWrite`/`writeReg`/`writeData`). It sits between the pipeline's result producers and the register file. It also provides a two-port read bypass so that operand reads see values still pending in the queue. The block is the initiator side of the register-file write interface; the register file remains a pure responder.

---
 rtl/rf_writeback_queue.sv | 115 +++++++++++
 tb/tb_rf_writeback_queue.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/rf_writeback_queue.sv
// Writeback queue in front of the register-file write port: buffers requests,
// drains one per cycle when the port is free, and bypasses pending values to readers.
module rf_writeback_queue #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 2,
    parameter int DEPTH      = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [ADDR_WIDTH-1:0]   in_reg,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    in_ready,
    input  logic                    drain_en,
    output logic                    regWrite,
    output logic [ADDR_WIDTH-1:0]   writeReg,
    output logic [DATA_WIDTH-1:0]   writeData,
    input  logic [ADDR_WIDTH-1:0]   readReg1,
    input  logic [ADDR_WIDTH-1:0]   readReg2,
    output logic                    byp_hit1,
    output logic                    byp_hit2,
    output logic [DATA_WIDTH-1:0]   byp_data1,
    output logic [DATA_WIDTH-1:0]   byp_data2,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty,
    output logic                    full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] reg_q  [DEPTH];
    logic [ADDR_WIDTH-1:0] reg_d  [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]      vld_q, vld_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  push, pop;
    logic [PTR_W-1:0]      idx;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CNT_W'(DEPTH));
        count    = count_q;
        in_ready = !full;
        push     = in_valid && in_ready;
        regWrite = !empty && drain_en;
        pop      = regWrite;

        writeReg  = empty ? '0 : reg_q[rd_ptr_q];
        writeData = empty ? '0 : data_q[rd_ptr_q];

        // Walk oldest to newest so the youngest matching entry is the one left standing.
        byp_hit1  = 1'b0;
        byp_hit2  = 1'b0;
        byp_data1 = '0;
        byp_data2 = '0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if (vld_q[idx] && reg_q[idx] == readReg1) begin
                byp_hit1  = 1'b1;
                byp_data1 = data_q[idx];
            end
            if (vld_q[idx] && reg_q[idx] == readReg2) begin
                byp_hit2  = 1'b1;
                byp_data2 = data_q[idx];
            end
        end

        reg_d    = reg_q;
        data_d   = data_q;
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // Push and pop never touch the same slot: push needs !full, pop needs !empty.
        if (push) begin
            reg_d[wr_ptr_q]  = in_reg;
            data_d[wr_ptr_q] = in_data;
            vld_d[wr_ptr_q]  = 1'b1;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                reg_q[i]  <= '0;
                data_q[i] <= '0;
            end
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            reg_q    <= reg_d;
            data_q   <= data_d;
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_rf_writeback_queue.sv
// Bench for rf_writeback_queue: directed scenarios plus random traffic,
// every cycle checked against a queue-based reference model.
module tb_rf_writeback_queue;
    localparam int DW = 24;
    localparam int AW = 2;
    localparam int DEPTH = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [AW-1:0] in_reg;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          drain_en;
    logic          regWrite;
    logic [AW-1:0] writeReg;
    logic [DW-1:0] writeData;
    logic [AW-1:0] readReg1, readReg2;
    logic          byp_hit1, byp_hit2;
    logic [DW-1:0] byp_data1, byp_data2;
    logic [2:0]    count;
    logic          empty, full;

    rf_writeback_queue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_reg(in_reg), .in_data(in_data), .in_ready(in_ready),
        .drain_en(drain_en), .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .readReg1(readReg1), .readReg2(readReg2),
        .byp_hit1(byp_hit1), .byp_hit2(byp_hit2), .byp_data1(byp_data1), .byp_data2(byp_data2),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [AW-1:0] r;
        logic [DW-1:0] d;
    } ent_t;

    ent_t mq[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_byp(input logic [AW-1:0] rr, output logic hit, output logic [DW-1:0] dat);
        hit = 1'b0;
        dat = '0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].r == rr) begin
                hit = 1'b1;
                dat = mq[i].d;
                break;
            end
        end
    endtask

    // One clock: drive at negedge, check combinational outputs, then advance the model at posedge.
    task automatic step(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d,
                        input logic de, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                        input logic rst);
        logic          e_hit1, e_hit2, e_wr, e_push;
        logic [DW-1:0] e_d1, e_d2;
        int            sz;
        @(negedge clock);
        in_valid = v; in_reg = r; in_data = d; drain_en = de;
        readReg1 = r1; readReg2 = r2; reset = rst;
        #1;
        sz = mq.size();
        e_wr   = (sz > 0) && de;
        e_push = v && (sz < DEPTH);
        chk("count", 32'(count), 32'(sz));
        chk("empty", 32'(empty), 32'(sz == 0));
        chk("full", 32'(full), 32'(sz == DEPTH));
        chk("in_ready", 32'(in_ready), 32'(sz < DEPTH));
        chk("regWrite", 32'(regWrite), 32'(e_wr));
        chk("writeReg", 32'(writeReg), (sz > 0) ? 32'(mq[0].r) : 32'd0);
        chk("writeData", 32'(writeData), (sz > 0) ? 32'(mq[0].d) : 32'd0);
        model_byp(r1, e_hit1, e_d1);
        model_byp(r2, e_hit2, e_d2);
        chk("byp_hit1", 32'(byp_hit1), 32'(e_hit1));
        chk("byp_data1", 32'(byp_data1), 32'(e_d1));
        chk("byp_hit2", 32'(byp_hit2), 32'(e_hit2));
        chk("byp_data2", 32'(byp_data2), 32'(e_d2));
        @(posedge clock);
        if (rst) begin
            mq.delete();
        end else begin
            if (e_wr) void'(mq.pop_front());
            if (e_push) mq.push_back(ent_t'{r: r, d: d});
        end
    endtask

    task automatic idle(input logic de, input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, de, 2'd2, 2'd3, 1'b0);
    endtask

    initial begin
        in_valid = 0; in_reg = '0; in_data = '0; drain_en = 0;
        readReg1 = '0; readReg2 = '0; reset = 1;
        repeat (2) @(posedge clock);

        // Reset state, then single push with drain: one-cycle latency.
        idle(1'b1, 2);
        step(1'b1, 2'd2, 24'd5, 1'b1, 2'd2, 2'd0, 1'b0);
        idle(1'b1, 2);

        // Fill with drain held, refuse a fifth request, then drain in order.
        step(1'b1, 2'd2, 24'd5, 1'b0, 2'd1, 2'd0, 1'b0);
        step(1'b1, 2'd3, 24'd4, 1'b0, 2'd1, 2'd0, 1'b0);
        step(1'b1, 2'd1, 24'd7, 1'b0, 2'd1, 2'd0, 1'b0);
        step(1'b1, 2'd0, 24'd9, 1'b0, 2'd1, 2'd0, 1'b0);
        step(1'b1, 2'd1, 24'd1, 1'b0, 2'd1, 2'd0, 1'b0);
        idle(1'b1, 5);

        // Youngest pending value wins the bypass.
        step(1'b1, 2'd2, 24'd5, 1'b0, 2'd2, 2'd3, 1'b0);
        step(1'b1, 2'd2, 24'd8, 1'b0, 2'd2, 2'd3, 1'b0);
        idle(1'b0, 1);
        idle(1'b1, 3);

        // Sustained push+pop across pointer wrap.
        for (int i = 1; i <= 10; i++)
            step(1'b1, AW'(i % 4), DW'(i), 1'b1, AW'(i % 4), AW'((i + 1) % 4), 1'b0);
        idle(1'b1, 2);

        // Full queue draining still refuses input that cycle.
        for (int i = 0; i < 4; i++) step(1'b1, AW'(i), DW'(20 + i), 1'b0, 2'd0, 2'd3, 1'b0);
        step(1'b1, 2'd3, 24'd30, 1'b1, 2'd3, 2'd0, 1'b0);
        step(1'b1, 2'd3, 24'd30, 1'b1, 2'd3, 2'd0, 1'b0);
        idle(1'b1, 5);

        // Reset mid-operation discards pending entries.
        for (int i = 0; i < 3; i++) step(1'b1, AW'(i), DW'(40 + i), 1'b0, 2'd1, 2'd2, 1'b0);
        step(1'b0, '0, '0, 1'b1, 2'd1, 2'd2, 1'b1);
        idle(1'b1, 3);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) < 7, AW'($urandom), DW'($urandom),
                 $urandom_range(0, 9) < ((i / 100) % 2 == 0 ? 6 : 3),
                 AW'($urandom), AW'($urandom), $urandom_range(0, 99) < 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
